// File: rtl/fft_bitrev_reader.sv
// fft_bitrev_reader
// Output reorder buffer for the radix-2 FFT back end. Samples arrive in
// bit-reversed index order and leave in natural order over a valid/ready
// stream. Two banks ping-pong so one frame fills while the previous drains.
// Optional framing check: define FFT_BITREV_CHECK_EN to compare in_last
// against the write counter and raise a sticky err flag on mismatch.
module fft_bitrev_reader #(
    parameter int WIDTH = 8,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             err
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

    // Reverse the LOG2N bits of an index (N = 8: 1 -> 4, 3 -> 6).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = v[LOG2N-1-b];
        end
        return r;
    endfunction

    // Storage: two banks of N packed {real, imag} words.
    logic [2*WIDTH-1:0] mem_q [2][N];

    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic [1:0]       full_q, full_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic [WIDTH-1:0] out_i_q, out_i_d;
    logic [LOG2N-1:0] out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;

    logic             in_ready_s;
    logic             in_hs_s;
    logic             load_s;
    logic [2*WIDTH-1:0] rd_word_s;

    // Handshake and load qualifiers; a full write bank blocks further writes.
    always_comb begin
        in_ready_s = ~full_q[wbank_q];
        in_hs_s    = in_valid & in_ready_s;
        load_s     = full_q[rbank_q] & (~out_valid_q | out_ready);
        rd_word_s  = mem_q[rbank_q][rcnt_q];
    end

    // Write-side counter and bank pointer advance on every accepted sample.
    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        if (in_hs_s) begin
            if (wcnt_q == LAST_IDX) begin
                wcnt_d  = '0;
                wbank_d = ~wbank_q;
            end else begin
                wcnt_d  = wcnt_q + LOG2N'(1);
            end
        end else begin
            wcnt_d  = wcnt_q;
        end
    end

    // Bank occupancy: write side sets, read side clears; they never hit the same bank.
    always_comb begin
        full_d = full_q;
        if (in_hs_s && (wcnt_q == LAST_IDX)) begin
            full_d[wbank_q] = 1'b1;
        end else begin
            full_d[wbank_q] = full_q[wbank_q];
        end
        if (load_s && (rcnt_q == LAST_IDX)) begin
            full_d[rbank_q] = 1'b0;
        end else begin
            full_d[rbank_q] = full_d[rbank_q];
        end
    end

    // Read side: load the output register in natural order, or drop valid once taken.
    always_comb begin
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        if (load_s) begin
            out_r_d     = rd_word_s[2*WIDTH-1:WIDTH];
            out_i_d     = rd_word_s[WIDTH-1:0];
            out_idx_d   = rcnt_q;
            out_last_d  = (rcnt_q == LAST_IDX);
            out_valid_d = 1'b1;
            if (rcnt_q == LAST_IDX) begin
                rcnt_d  = '0;
                rbank_d = ~rbank_q;
            end else begin
                rcnt_d  = rcnt_q + LOG2N'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

`ifdef FFT_BITREV_CHECK_EN
    // Sticky framing error: in_last must coincide with the final write slot.
    always_comb begin
        if (in_hs_s && (in_last != (wcnt_q == LAST_IDX))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end
`else
    logic unused_in_last_s;
    assign unused_in_last_s = in_last;

    // Framing check disabled: err stays low.
    always_comb begin
        err_d = 1'b0;
    end
`endif

    // Sample storage write; contents need no reset because full_q gates reads.
    always_ff @(posedge clk) begin
        if (in_hs_s) begin
            mem_q[wbank_q][bitrev(wcnt_q)] <= {in_r, in_i};
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Scoreboard bench for fft_bitrev_reader (N = 8, WIDTH = 8).
module tb_fft_bitrev_reader;

    localparam int WIDTH = 8;
    localparam int LOG2N = 3;
    localparam int N     = 8;
`ifdef FFT_BITREV_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [7:0] r;
        logic [7:0] i;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_r = 8'h00;
    logic [WIDTH-1:0] in_i = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_i;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;
    logic             err;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    logic [15:0] frame_buf[$];
    bit   rdy_rand = 1'b0;
    bit   rdy_val  = 1'b0;
    bit   strict   = 1'b0;
    bit   gap_mon  = 1'b0;
    bit   seen_out = 1'b0;
    int   gaps     = 0;

    fft_bitrev_reader #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_i(in_i), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx),
        .out_last(out_last), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: reverse the bits of an index by repeated halving.
    function automatic int rev(input int j);
        int v = j;
        int r = 0;
        for (int b = 0; b < LOG2N; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Model: the k-th arriving sample carries natural index rev(k).
    task automatic record(input logic [7:0] r, input logic [7:0] i);
        frame_buf.push_back({r, i});
        if (frame_buf.size() == N) begin
            for (int j = 0; j < N; j++) begin
                exp_t e;
                e.r    = frame_buf[rev(j)][15:8];
                e.i    = frame_buf[rev(j)][7:0];
                e.idx  = 3'(j);
                e.last = (j == N - 1);
                exp_q.push_back(e);
            end
            frame_buf.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] i, input logic last);
        int  tries = 0;
        bit  done  = 1'b0;
        in_valid = 1'b1;
        in_r     = r;
        in_i     = i;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (strict && tries == 0) check("in_ready_strict", 32'(in_ready), 32'd1);
            if (in_ready) begin
                record(r, i);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 1000) begin
                    n_checks++;
                    $display("FAIL push_timeout: got in_ready 0 expected 1 within 1000 cycles");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_frame(input int last_pos, input bit rnd, input bit gaps_on);
        for (int k = 0; k < N; k++) begin
            logic [7:0] r;
            logic [7:0] i;
            if (rnd) begin
                r = 8'($urandom);
                i = 8'($urandom);
            end else begin
                r = 8'(k);
                i = 8'(8'h80 + k);
            end
            if (gaps_on) idle($urandom_range(0, 2));
            push(r, i, (k == last_pos));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
        idle(2);
        check({name, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    // Downstream ready driver.
    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    // Monitor: every presented output must equal the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (gap_mon) seen_out = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got idx %0d with empty scoreboard", out_idx);
                end else begin
                    check("out_r",    32'(out_r),    32'(exp_q[0].r));
                    check("out_i",    32'(out_i),    32'(exp_q[0].i));
                    check("out_idx",  32'(out_idx),  32'(exp_q[0].idx));
                    check("out_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else if (gap_mon && seen_out && exp_q.size() != 0) begin
                gaps++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        idle(3);
        rst_n   = 1'b1;
        rdy_val = 1'b1;
        idle(2);

        // Single frame with latency check
        push_frame(7, 1'b0, 1'b0);
        @(negedge clk);
        check("latency_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        wait_drain("single_drain");

        // Reset mid-write discards partial frame
        for (int k = 0; k < 3; k++) push(8'(8'h40 + k), 8'(k), 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err",       32'(err),       32'd0);
        frame_buf.delete();
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        push_frame(7, 1'b1, 1'b0);
        wait_drain("after_rst_drain");

        // Back-to-back frames
        strict  = 1'b1;
        gap_mon = 1'b1;
        seen_out = 1'b0;
        gaps    = 0;
        for (int f = 0; f < 3; f++) push_frame(7, 1'b1, 1'b0);
        strict = 1'b0;
        wait_drain("b2b_drain");
        gap_mon = 1'b0;
        check("b2b_gaps", 32'(gaps), 32'd0);

        // Backpressure: both banks fill, then drain
        rdy_val = 1'b0;
        idle(1);
        push_frame(7, 1'b1, 1'b0);
        push_frame(7, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready),  32'd0);
        check("bp_out_valid",    32'(out_valid), 32'd1);
        idle(5);
        @(negedge clk);
        check("bp_in_ready_held", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
        wait_drain("bp_drain");
        check("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Random stalls on both sides
        rdy_rand = 1'b1;
        for (int f = 0; f < 10; f++) push_frame(7, 1'b1, 1'b1);
        rdy_rand = 1'b0;
        rdy_val  = 1'b1;
        wait_drain("rand_drain");
        check("err_clean", 32'(err), 32'd0);

        // Misplaced in_last
        push_frame(5, 1'b0, 1'b0);
        wait_drain("badlast_drain");
        check("err_set", 32'(err), 32'(EXP_ERR));
        push_frame(7, 1'b1, 1'b0);
        wait_drain("sticky_drain");
        check("err_sticky", 32'(err), 32'(EXP_ERR));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
